hdb3_decoder: RTL

Receive-side HDB3 decoder for the HDB3 encode/decode chain. It accepts a stream of ternary line symbols and detects bipolar violations (V pulses), then removes the 000V and B00V substitutions to restore the original binary stream. It also flags line-code errors. It is the counterpart of the encoder-side B-insertion stage and feeds the downstream binary sink. The output timing uses the same enable-delayed "instruction" convention as the encoder chain.

---
 rtl/hdb3_decoder.sv | 64 ++++++
 1 files changed

// File: rtl/hdb3_decoder.sv
// HDB3 line decoder: tracks pulse polarity, detects bipolar violations and
// strips 000V / B00V substitutions through a 4-deep delay line (falling-edge).
module hdb3_decoder #(
   parameter bit ERR_STICKY = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] hdb3_data,
   output logic       decoded_data,
   output logic       decoded_valid,
   output logic       code_err
);

   typedef enum logic [1:0] {POL_NONE, POL_POS, POL_NEG} pol_t;

   pol_t       last_pol, pol_next;
   logic [3:0] d, v, d_next, v_next;
   logic       active, is_pos, is_neg, pulse, illegal, viol, err_now;

   // Flush keeps the line moving while any valid symbol is still in flight.
   assign active  = en | (|v);
   assign is_pos  = en & (hdb3_data == 2'b01);
   assign is_neg  = en & (hdb3_data == 2'b10);
   assign illegal = en & (hdb3_data == 2'b11);
   assign pulse   = is_pos | is_neg;
   assign viol    = (is_pos && last_pol == POL_POS) || (is_neg && last_pol == POL_NEG);

   always_comb begin
      pol_next = last_pol;
      d_next   = d;
      v_next   = v;
      err_now  = 1'b0;
      if (!active) begin
         pol_next = POL_NONE;
      end else begin
         v_next = {v[2:0], en};
         if (is_pos)      pol_next = POL_POS;
         else if (is_neg) pol_next = POL_NEG;
         // A V wipes itself and the three symbols before it; this covers both
         // 000V and B00V without needing to tell them apart.
         d_next  = viol ? 4'b0000 : {d[2:0], pulse};
         err_now = illegal | (viol & ((d[0] & v[0]) | (d[1] & v[1])));
      end
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         last_pol <= POL_NONE;
         d        <= 4'b0000;
         v        <= 4'b0000;
         code_err <= 1'b0;
      end else begin
         last_pol <= pol_next;
         d        <= d_next;
         v        <= v_next;
         code_err <= ERR_STICKY ? (code_err | err_now) : err_now;
      end
   end

   assign decoded_data  = d[3] & v[3];
   assign decoded_valid = v[3];

endmodule
